// File: rtl/rr_priority_encoder_pkg.sv
// rr_priority_encoder_pkg
// Shared types and constants for the registered round-robin priority encoder.
//   state_t     : handshake FSM states (IDLE = no grant held, HOLD = grant held)
//   MODE_FIXED  : selector mode, highest set index wins
//   MODE_RR     : selector mode, search starts just below the last granted index
//   clog2()     : index width helper, usable in constant expressions
package rr_priority_encoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Number of bits needed to hold the values 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_encoder_if.sv
// rr_priority_encoder_if
// Request/grant bundle between request sources, the encoder and one consumer.
//   a         : request vector, bit i = source i requesting
//   b         : encoded index of the granted source
//   b_valid   : b holds a grant
//   b_ready   : consumer accepts the grant on a clk edge where b_valid = 1
//   multi     : more than one request was set when the grant was captured
//   grant_cnt : accepted grants since reset, wraps
//   state     : encoder FSM state, exposed for observation
// Handshake: a grant transfers on every rising clk edge where b_valid and
// b_ready are both 1. While b_valid = 1 and b_ready = 0, b and multi stay
// stable. b_ready is don't-care while b_valid = 0.
// Modports: slave = the encoder, master = the request side / consumer.
interface rr_priority_encoder_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    import rr_priority_encoder_pkg::*;

    localparam int W = clog2(N);

    logic [N-1:0]     a;
    logic [W-1:0]     b;
    logic             b_valid;
    logic             b_ready;
    logic             multi;
    logic [CNT_W-1:0] grant_cnt;
    state_t           state;

    modport slave (
        input  a,
        input  b_ready,
        output b,
        output b_valid,
        output multi,
        output grant_cnt,
        output state
    );

    modport master (
        output a,
        output b_ready,
        input  b,
        input  b_valid,
        input  multi,
        input  grant_cnt,
        input  state
    );

endinterface

// File: rtl/rr_priority_encoder_prio_select.sv
// prio_select
// Combinational priority selector shared by fixed and round-robin modes.
//   a     : request vector
//   last  : last granted index (ignored in fixed mode)
//   mode  : MODE_FIXED or MODE_RR
//   index : winning index, always in 0..N-1
//   any   : at least one request set
//   multi : more than one request set
// The request vector is rotated so that position j holds request
// (base-1-j) mod N, the lowest set position is found, and the position is
// mapped back to a request index. With base = 0 the search order is
// N-1 down to 0, which is exactly the fixed-priority order.
module prio_select
    import rr_priority_encoder_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] a,
    input  logic [W-1:0] last,
    input  logic         mode,
    output logic [W-1:0] index,
    output logic         any,
    output logic         multi
);

    logic [N-1:0] rot;
    logic [W-1:0] base;
    logic         found;
    int           pos;
    int           t;
    int           u;

    always_comb begin
        base  = (mode == MODE_RR) ? last : '0;
        rot   = '0;
        found = 1'b0;
        pos   = 0;
        t     = 0;
        u     = 0;

        // Rotate: base <= N-1 and j <= N-1, so one wrap correction suffices.
        for (int j = 0; j < N; j++) begin
            t = int'(base) - 1 - j;
            if (t < 0) begin
                t = t + N;
            end
            rot[j] = a[t];
        end

        // Priority-find: lowest rotated position wins.
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pos   = j;
            end
        end

        // Unrotate back to a request index.
        u = int'(base) - 1 - pos;
        if (u < 0) begin
            u = u + N;
        end
        index = u[W-1:0];
    end

    assign any   = |a;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(a & (a - N'(1)));

endmodule

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
// Registered N-to-W priority encoder with a valid/ready output handshake and
// selectable fixed or round-robin priority.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset; drops any pending grant at once
//   bus : rr_priority_encoder_if.slave (a, b, b_valid, b_ready, multi,
//         grant_cnt, state)
// Parameters: N request inputs (2..64), ROUND_ROBIN (0 fixed, 1 round-robin),
// CNT_W grant counter width. The index width W is derived from N.
module rr_priority_encoder
    import rr_priority_encoder_pkg::*;
#(
    parameter int N           = 4,
    parameter int ROUND_ROBIN = 0,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_priority_encoder_if.slave  bus
);

    localparam int   W    = clog2(N);
    localparam logic MODE = (ROUND_ROBIN != 0) ? MODE_RR : MODE_FIXED;

    state_t           state;
    state_t           next_state;
    logic [W-1:0]     b_q;
    logic             multi_q;
    logic [W-1:0]     last_q;
    logic [CNT_W-1:0] cnt_q;

    logic [W-1:0]     sel_last;
    logic [W-1:0]     sel_index;
    logic             sel_any;
    logic             sel_multi;
    logic             accept;
    logic             load;

    prio_select #(
        .N (N),
        .W (W)
    ) u_sel (
        .a     (bus.a),
        .last  (sel_last),
        .mode  (MODE),
        .index (sel_index),
        .any   (sel_any),
        .multi (sel_multi)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (bus.b_ready && !sel_any) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        accept = (state == HOLD) && bus.b_ready;
        load   = (state == IDLE) ? sel_any : (accept && sel_any);
        // On an accepting edge the grant being retired is the new pointer,
        // so a back-to-back grant is selected relative to b, not last.
        sel_last = (state == HOLD) ? b_q : last_q;
    end

    // Grant datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q     <= '0;
            multi_q <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                last_q <= b_q;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (load) begin
                b_q     <= sel_index;
                multi_q <= sel_multi;
            end
        end
    end

    // b_valid follows the state so that reset clears it asynchronously.
    assign bus.b_valid   = (state == HOLD);
    assign bus.b         = b_q;
    assign bus.multi     = multi_q;
    assign bus.grant_cnt = cnt_q;
    assign bus.state     = state;

endmodule
